spi_buf_tx: RTL and testbench

- SPI mode-0 frame transmitter.
- Drains a byte buffer (32 entries, synchronous-read RAM written by the UART receive path) onto spi_clock/spi_data/cs_n when a send is requested.
- Sits directly downstream of the receive buffer; drives the chip-level SPI pins and the done_send indication.

---
 rtl/spi_buf_tx.sv | 206 ++++++++++++++++++++
 tb/tb_spi_buf_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_buf_tx.sv
// spi_buf_tx: SPI mode-0 frame transmitter.
// Reads len bytes from a synchronous-read byte buffer starting at address 0
// and shifts them out MSB first on spi_clock/spi_data while cs_n is held low.
// done_send pulses for one cycle at the end of every frame.
// Optional feature macro: SPI_TX_LSB_FIRST_EN adds a lsb_first input that
// selects LSB-first bit order per frame (latched when start is accepted).
module spi_buf_tx #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
`ifdef SPI_TX_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              spi_clock,
    output logic              spi_data,
    output logic              cs_n,
    output logic              busy,
    output logic              done_send
);

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StShift,
        StTail,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;      // bytes still to load after the current one
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              sclk_q, sclk_d;
    logic              sdata_q, sdata_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef SPI_TX_LSB_FIRST_EN
    logic              lsb_q, lsb_d;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        rd_addr_d = rd_addr_q;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
`ifdef SPI_TX_LSB_FIRST_EN
        lsb_d     = lsb_q;
`endif

        unique case (state_q)
            StIdle: begin
                div_d = '0;
                bit_d = '0;
                if (start) begin
                    if (len == '0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d     = len;
                        rd_addr_d = '0;
                        state_d   = StFetch;
`ifdef SPI_TX_LSB_FIRST_EN
                        lsb_d     = lsb_first;
`endif
                    end
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                shift_d   = rd_data;
`ifdef SPI_TX_LSB_FIRST_EN
                sdata_d   = lsb_q ? rd_data[0] : rd_data[7];
`else
                sdata_d   = rd_data[7];
`endif
                rd_addr_d = rd_addr_q + 1'b1;
                cnt_d     = cnt_q - 1'b1;
                div_d     = '0;
                bit_d     = '0;
                sclk_d    = 1'b0;
                state_d   = StShift;
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        // Falling edge: advance to the next bit or the next byte.
                        if (bit_q == 3'd7) begin
                            bit_d = '0;
                            if (cnt_q != '0) begin
                                shift_d   = rd_data;
`ifdef SPI_TX_LSB_FIRST_EN
                                sdata_d   = lsb_q ? rd_data[0] : rd_data[7];
`else
                                sdata_d   = rd_data[7];
`endif
                                rd_addr_d = rd_addr_q + 1'b1;
                                cnt_d     = cnt_q - 1'b1;
                            end else begin
                                state_d = StTail;
                            end
                        end else begin
                            bit_d = bit_q + 3'd1;
                            // Rotate rather than shift; bits past the eighth are never sent.
`ifdef SPI_TX_LSB_FIRST_EN
                            if (lsb_q) begin
                                shift_d = {shift_q[0], shift_q[7:1]};
                                sdata_d = shift_q[1];
                            end else begin
                                shift_d = {shift_q[6:0], shift_q[7]};
                                sdata_d = shift_q[6];
                            end
`else
                            shift_d = {shift_q[6:0], shift_q[7]};
                            sdata_d = shift_q[6];
`endif
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StTail: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    state_d = StDone;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        cs_n_d = !((state_d == StShift) || (state_d == StTail));
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            rd_addr_q <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPI_TX_LSB_FIRST_EN
            lsb_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rd_addr_q <= rd_addr_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SPI_TX_LSB_FIRST_EN
            lsb_q     <= lsb_d;
`endif
        end
    end

    assign rd_addr   = rd_addr_q;
    assign spi_clock = sclk_q;
    assign spi_data  = sdata_q;
    assign cs_n      = cs_n_q;
    assign busy      = busy_q;
    assign done_send = done_q;

endmodule

// File: tb/tb_spi_buf_tx.sv
// tb_spi_buf_tx: directed bench for spi_buf_tx with a sync-RAM model and a
// bit scoreboard; expected bits are queued at start and popped on each
// observed spi_clock rising edge.
module tb_spi_buf_tx;

    localparam int ADDR_W = 5;
    localparam int H      = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
`ifdef SPI_TX_LSB_FIRST_EN
    logic              lsb_first;
`endif
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              spi_clock;
    logic              spi_data;
    logic              cs_n;
    logic              busy;
    logic              done_send;

    logic [7:0] mem [32];
    logic       exp_q [$];

    int vectors = 0;
    int errors  = 0;

    int cyc = 0;
    int n_rise, cs_low, done_cnt, done_coinc, busy_cycles, gap_bad, last_rise;
    int cs_fall, first_delay;
    logic prev_sclk, prev_cs_n;

    spi_buf_tx #(
        .ADDR_W  (ADDR_W),
        .CLK_DIV (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
`ifdef SPI_TX_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .spi_clock (spi_clock),
        .spi_data  (spi_data),
        .cs_n      (cs_n),
        .busy      (busy),
        .done_send (done_send)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read buffer model.
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_rise = 0; cs_low = 0; done_cnt = 0; done_coinc = 0;
        busy_cycles = 0; gap_bad = 0; last_rise = 0; cs_fall = 0; first_delay = -1;
    endtask

    // Monitor: sampled on the falling clk edge, away from DUT updates.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_sclk = 1'b0;
            prev_cs_n = 1'b1;
        end else begin
            if (busy) busy_cycles++;
            if (!cs_n) cs_low++;
            if (!cs_n && prev_cs_n) cs_fall = cyc;
            if (done_send) begin
                done_cnt++;
                if (!prev_cs_n && cs_n) done_coinc++;
            end
            if (spi_clock && !prev_sclk) begin
                if (n_rise == 0) first_delay = cyc - cs_fall;
                else if (cyc - last_rise != 2 * H) gap_bad++;
                last_rise = cyc;
                n_rise++;
                if (exp_q.size() > 0) check("bit", spi_data, exp_q.pop_front());
            end
            prev_sclk = spi_clock;
            prev_cs_n = cs_n;
        end
    end

    task automatic send(input int n, input bit lsb);
        for (int b = 0; b < n; b++)
            for (int k = 0; k < 8; k++)
                exp_q.push_back(mem[b][lsb ? k : 7 - k]);
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1;
        len   = (ADDR_W + 1)'(n);
`ifdef SPI_TX_LSB_FIRST_EN
        lsb_first = lsb;
`endif
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_send) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0;
`ifdef SPI_TX_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", spi_clock, 0);
        check("rst_sdata", spi_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_send, 0);
        check("rst_addr", rd_addr, 0);
        rst = 1'b0;

        // Reset in the middle of a 3-byte frame.
        mem[0] = 8'hA5; mem[1] = 8'h5A; mem[2] = 8'hC3;
        send(3, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        check("mid_cs_low_before", cs_n, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_cs_n", cs_n, 1);
        check("mid_rst_sclk", spi_clock, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", rd_addr, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_no_done", done_cnt, 0);
        check("mid_cs_idle", cs_n, 1);

        // Clean single byte 0xA5.
        send(1, 1'b0);
        wait_done(200);
        check("b1_rises", n_rise, 8);
        check("b1_cs_low", cs_low, 17 * H);
        check("b1_first_rise", first_delay, H);
        check("b1_done_cnt", done_cnt, 1);
        check("b1_done_coinc", done_coinc, 1);
        check("b1_busy", busy_cycles, 71);
        check("b1_q_empty", exp_q.size(), 0);

        // Multi-byte continuity.
        mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hFF;
        send(3, 1'b0);
        wait_done(600);
        check("b3_rises", n_rise, 24);
        check("b3_gaps", gap_bad, 0);
        check("b3_cs_low", cs_low, 49 * H);
        check("b3_addr", rd_addr, 3);
        check("b3_q_empty", exp_q.size(), 0);

        // Zero length.
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1; len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("z_done_hi", done_send, 1);
        @(posedge clk); #1;
        check("z_done_lo", done_send, 0);
        repeat (3) @(posedge clk);
        #1;
        check("z_cs_low", cs_low, 0);
        check("z_done_cnt", done_cnt, 1);
        check("z_busy", busy_cycles, 1);
        check("z_rises", n_rise, 0);

        // Start pulses while busy are ignored.
        mem[0] = 8'h3C; mem[1] = 8'hC3;
        send(2, 1'b0);
        for (int p = 0; p < 3; p++) begin
            repeat (20) @(posedge clk);
            #1; start = 1'b1; len = 6'd5;
            @(posedge clk); #1; start = 1'b0;
        end
        wait_done(400);
        repeat (10) @(posedge clk);
        #1;
        check("bz_rises", n_rise, 16);
        check("bz_done_cnt", done_cnt, 1);
        check("bz_cs_low", cs_low, 33 * H);
        check("bz_idle", busy, 0);

        // Full buffer with address wrap.
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        send(32, 1'b0);
        wait_done(5000);
        check("full_rises", n_rise, 256);
        check("full_gaps", gap_bad, 0);
        check("full_addr", rd_addr, 0);
        check("full_cs_low", cs_low, 513 * H);
        check("full_q_empty", exp_q.size(), 0);

`ifdef SPI_TX_LSB_FIRST_EN
        mem[0] = 8'h01;
        send(1, 1'b1);
        wait_done(200);
        check("lsb_rises", n_rise, 8);
        check("lsb_q_empty", exp_q.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
